uart_rx: RTL and testbench

Serial receiver that deserialises 8N1 UART frames from the host link and presents one byte per frame to the IO controller. It sits directly upstream of the IO controller. Its one-cycle `rx_done` pulse starts the controller's RAM write sequence for `rx_data` at the current write address. It has no back-pressure: the controller must finish each write before the next frame completes.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: constants and FSM state type shared by the UART receiver and transmitter.
// latency: n/a (package only).
// backpressure: n/a (package only).
package uart_pkg;

  // Default bit period: 50 MHz core clock / 115200 baud.
  localparam int CLKS_PER_BIT_DEF = 434;

  // Data bits per 8N1 frame.
  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// sync_2ff: two-flop synchroniser for a single asynchronous input bit.
// latency: 2 clk cycles from d to q.
// backpressure: none; the output follows the input continuously.
//
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-low reset; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronised output
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 UART receiver, one byte per frame to the IO controller.
// latency: rx_done/rx_error high the cycle after edge E+2+H+9N (E = first flop sees start bit).
// backpressure: none; the consumer must absorb each byte before the next frame completes.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   rx       - serial line, asynchronous, idles high
//   rx_data  - last correctly framed byte, held until the next good frame
//   rx_done  - one-cycle pulse when rx_data has just been updated
//   rx_error - one-cycle pulse when the stop bit was sampled low
//   rx_busy  - high while the receiver is outside IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_done,
  output logic                  rx_error,
  output logic                  rx_busy
);

  localparam int N  = CLKS_PER_BIT;
  localparam int H  = N / 2;
  localparam int CW = $clog2(N);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [2:0]    IDX_LAST = 3'(FRAME_BITS - 1);

  logic rx_s;

  // Line idles high, so the synchroniser resets to 1 to avoid a fake start bit.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_t           state,    state_nxt;
  logic [CW-1:0]         cnt,      cnt_nxt;
  logic [2:0]            idx,      idx_nxt;
  logic [FRAME_BITS-1:0] shreg,    shreg_nxt;
  logic [FRAME_BITS-1:0] data_nxt;
  logic                  done_nxt;
  logic                  err_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      shreg    <= shreg_nxt;
      rx_data  <= data_nxt;
      rx_done  <= done_nxt;
      rx_error <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    data_nxt  = rx_data;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end

      // Re-check the start bit at its midpoint; a high line here was a glitch.
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      // Counting from the start-bit midpoint, every N cycles lands mid-bit.
      DATA: begin
        if (cnt == CNT_LAST) begin
          shreg_nxt[idx] = rx_s;
          cnt_nxt        = '0;
          if (idx == IDX_LAST) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      // Returning to IDLE at the stop midpoint leaves half a bit to catch a
      // back-to-back start bit.
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shreg;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      // A line held low after a framing error must not look like a new start bit.
      BREAK: begin
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  N          = 16;
  localparam int  H          = N / 2;
  localparam real CLK_NS     = 10.0;
  localparam real BIT_NS     = N * CLK_NS;
  // Edges from E (first flop sees start) to the stop-bit sample edge.
  localparam int  SAMPLE_OFS = 2 + H + 9 * N;
  localparam int  FRAME_CYC  = 10 * N;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_error;
  logic       rx_busy;

  uart_rx #(
    .CLKS_PER_BIT (N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_error (rx_error),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; read at negedges it names the last edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Pulse recorder: every high cycle of a pulse becomes one entry.
  int         done_cyc[$];
  logic [7:0] done_dat[$];
  int         err_cyc[$];
  int         both_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (rx_done) begin
        done_cyc.push_back(cyc);
        done_dat.push_back(rx_data);
      end
      if (rx_error) err_cyc.push_back(cyc);
      if (rx_done && rx_error) both_cnt++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v, input real ns);
    rx = v;
    #(ns);
  endtask

  task automatic send_frame(input logic [7:0] b, input real ns);
    send_bit(1'b0, ns);
    for (int i = 0; i < 8; i++) send_bit(b[i], ns);
    send_bit(1'b1, ns);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic clear_q();
    done_cyc.delete();
    done_dat.delete();
    err_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         e;
    logic [7:0] frames[3];
    logic [7:0] hold;

    // ---- reset values ----
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_done", rx_done, 1'b0);
    check("reset_rx_error", rx_error, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy_after_release", rx_busy, 1'b0);

    // ---- single frame 8'hA5 ----
    e = cyc + 1;
    send_frame(8'hA5, BIT_NS);
    repeat (2 * N) @(negedge clk);
    check("a5_done_count", done_cyc.size(), 1);
    if (done_cyc.size() >= 1) begin
      check("a5_done_cycle", done_cyc[0], e + SAMPLE_OFS);
      check("a5_done_data", done_dat[0], 8'hA5);
    end
    check("a5_rx_data_held", rx_data, 8'hA5);
    check("a5_no_error", err_cyc.size(), 0);
    clear_q();

    // ---- three back-to-back frames ----
    frames[0] = 8'h00;
    frames[1] = 8'hFF;
    frames[2] = 8'h3C;
    e = cyc + 1;
    for (int f = 0; f < 3; f++) send_frame(frames[f], BIT_NS);
    repeat (2 * N) @(negedge clk);
    check("b2b_done_count", done_cyc.size(), 3);
    for (int f = 0; f < 3; f++) begin
      if (done_cyc.size() > f) begin
        check($sformatf("b2b_cycle_%0d", f), done_cyc[f], e + SAMPLE_OFS + f * FRAME_CYC);
        check($sformatf("b2b_data_%0d", f), done_dat[f], frames[f]);
      end
    end
    check("b2b_no_error", err_cyc.size(), 0);
    clear_q();

    // ---- 5-cycle glitch ----
    e = cyc + 1;
    rx = 1'b0;
    #(5 * CLK_NS);
    rx = 1'b1;
    wait_cyc(e + 1 + H);
    check("glitch_busy_before_check", rx_busy, 1'b1);
    wait_cyc(e + 2 + H);
    check("glitch_idle_at_e10", rx_busy, 1'b0);
    repeat (3 * N) @(negedge clk);
    check("glitch_no_done", done_cyc.size(), 0);
    check("glitch_no_error", err_cyc.size(), 0);
    check("glitch_data_kept", rx_data, 8'h3C);
    clear_q();

    // ---- framing error: 8'h5A with stop low for 3 bit times ----
    hold = rx_data;
    e = cyc + 1;
    send_bit(1'b0, BIT_NS);
    for (int i = 0; i < 8; i++) send_bit(hold[0] ^ hold[0] ^ (8'h5A >> i) & 1'b1, BIT_NS);
    send_bit(1'b0, 3 * BIT_NS);
    check("ferr_error_count", err_cyc.size(), 1);
    if (err_cyc.size() >= 1) check("ferr_error_cycle", err_cyc[0], e + SAMPLE_OFS);
    check("ferr_busy_in_break", rx_busy, 1'b1);
    check("ferr_no_done", done_cyc.size(), 0);
    check("ferr_data_kept", rx_data, hold);
    rx = 1'b1;
    repeat (N) @(negedge clk);
    check("ferr_idle_after_rise", rx_busy, 1'b0);
    check("ferr_no_retrigger", err_cyc.size() + done_cyc.size(), 1);
    clear_q();
    e = cyc + 1;
    send_frame(8'h81, BIT_NS);
    repeat (2 * N) @(negedge clk);
    check("post_ferr_done_count", done_cyc.size(), 1);
    if (done_cyc.size() >= 1) begin
      check("post_ferr_cycle", done_cyc[0], e + SAMPLE_OFS);
      check("post_ferr_data", done_dat[0], 8'h81);
    end
    check("post_ferr_no_error", err_cyc.size(), 0);
    clear_q();

    // ---- reset during data bit 4 of 8'hC3 ----
    send_bit(1'b0, BIT_NS);
    for (int i = 0; i < 4; i++) send_bit((8'hC3 >> i) & 1'b1, BIT_NS);
    send_bit((8'hC3 >> 4) & 1'b1, BIT_NS / 2.0);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_reset_rx_data", rx_data, 8'h00);
    check("mid_reset_busy", rx_busy, 1'b0);
    check("mid_reset_done", rx_done, 1'b0);
    check("mid_reset_error", rx_error, 1'b0);
    reset = 1'b1;
    repeat (2 * N) @(negedge clk);
    check("mid_reset_no_done", done_cyc.size(), 0);
    check("mid_reset_busy_after", rx_busy, 1'b0);
    e = cyc + 1;
    send_frame(8'h7E, BIT_NS);
    repeat (2 * N) @(negedge clk);
    check("post_reset_done_count", done_cyc.size(), 1);
    if (done_cyc.size() >= 1) begin
      check("post_reset_cycle", done_cyc[0], e + SAMPLE_OFS);
      check("post_reset_data", done_dat[0], 8'h7E);
    end
    clear_q();

    // ---- baud tolerance +2% / -2% ----
    send_frame(8'h96, BIT_NS * 1.02);
    repeat (3 * N) @(negedge clk);
    check("slow_done_count", done_cyc.size(), 1);
    if (done_dat.size() >= 1) check("slow_data", done_dat[0], 8'h96);
    check("slow_no_error", err_cyc.size(), 0);
    clear_q();
    send_frame(8'h96, BIT_NS * 0.98);
    repeat (3 * N) @(negedge clk);
    check("fast_done_count", done_cyc.size(), 1);
    if (done_dat.size() >= 1) check("fast_data", done_dat[0], 8'h96);
    check("fast_no_error", err_cyc.size(), 0);
    clear_q();

    // ---- randomized frames against the byte/timing model ----
    for (int r = 0; r < 6; r++) begin
      logic [7:0] b;
      int         gap;
      b   = 8'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 3 * N));
      repeat (gap) @(negedge clk);
      e = cyc + 1;
      send_frame(b, BIT_NS);
      repeat (N) @(negedge clk);
      check($sformatf("rand_%0d_count", r), done_cyc.size(), 1);
      if (done_cyc.size() >= 1) begin
        check($sformatf("rand_%0d_cycle", r), done_cyc[0], e + SAMPLE_OFS);
        check($sformatf("rand_%0d_data", r), done_dat[0], b);
      end
      check($sformatf("rand_%0d_rx_data", r), rx_data, b);
      clear_q();
    end

    check("never_done_and_error", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
